// File: rtl/window_conv_mac_pkg.sv
// Shared widths, FSM encoding and payload structs for the 3x3 window MAC stage.
package window_conv_mac_pkg;

  localparam int unsigned DATA_WIDTH       = 4;
  localparam int unsigned HALF_WINDOW_SIZE = 1;
  localparam int unsigned WINDOW_SIZE      = 2 * HALF_WINDOW_SIZE + 1;
  localparam int unsigned TAPS             = WINDOW_SIZE * WINDOW_SIZE;
  localparam int unsigned COEF_WIDTH       = 8;
  localparam int unsigned ACC_WIDTH        = DATA_WIDTH + COEF_WIDTH + 5;
  localparam int unsigned ADDR_WIDTH       = 16;
  localparam int unsigned CNT_WIDTH        = $clog2(TAPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Window snapshot taken on acceptance; immune to later input changes.
  typedef struct packed {
    logic [TAPS*DATA_WIDTH-1:0] value;
    logic [TAPS*COEF_WIDTH-1:0] coef;
    logic [ACC_WIDTH-1:0]       thr;
    logic [ADDR_WIDTH-1:0]      addr;
  } window_t;

  typedef struct packed {
    logic [ACC_WIDTH-1:0]  result;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  spike;
  } result_t;

endpackage

// File: rtl/window_conv_mac_if.sv
// Window-in / result-out bus between the scheduler, the MAC stage and the neuron update stage.
interface window_conv_mac_if;
  import window_conv_mac_pkg::*;

  logic [TAPS*DATA_WIDTH-1:0] in_window_value;
  logic [ADDR_WIDTH-1:0]      in_window_addr;
  logic                       in_window_valid;
  logic                       window_req;
  logic [TAPS*COEF_WIDTH-1:0] kernel_coef;
  logic [ACC_WIDTH-1:0]       threshold;
  logic [ACC_WIDTH-1:0]       out_result;
  logic [ADDR_WIDTH-1:0]      out_addr;
  logic                       out_spike;
  logic                       out_valid;
  logic                       out_ready;
  logic                       overrun;

  modport master (
    output in_window_value, in_window_addr, in_window_valid, kernel_coef, threshold, out_ready,
    input  window_req, out_result, out_addr, out_spike, out_valid, overrun
  );

  modport slave (
    input  in_window_value, in_window_addr, in_window_valid, kernel_coef, threshold, out_ready,
    output window_req, out_result, out_addr, out_spike, out_valid, overrun
  );

endinterface

// File: rtl/window_conv_mac_tap_mul.sv
// Single-tap product: unsigned event value times signed coefficient, widened to accumulator width.
module tap_mul
  import window_conv_mac_pkg::*;
(
  input  logic        [DATA_WIDTH-1:0] data_i,
  input  logic signed [COEF_WIDTH-1:0] coef_i,
  output logic signed [ACC_WIDTH-1:0]  prod_o
);

  logic signed [ACC_WIDTH-1:0] data_ext;
  logic signed [ACC_WIDTH-1:0] coef_ext;

  assign data_ext = $signed({{(ACC_WIDTH - DATA_WIDTH){1'b0}}, data_i});
  assign coef_ext = ACC_WIDTH'(coef_i);
  assign prod_o   = data_ext * coef_ext;

endmodule

// File: rtl/window_conv_mac.sv
// Sequential 3x3 weighted sum: latch a window, one MAC per cycle, present result with spike flag.
module window_conv_mac
  import window_conv_mac_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  window_conv_mac_if.slave    bus
);

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        tap_cnt_q, tap_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  window_t                     win_q, win_d;
  result_t                     res_q, res_d;
  logic                        out_valid_q, out_valid_d;
  logic                        overrun_q, overrun_d;

  logic [DATA_WIDTH-1:0]       tap_val;
  logic [COEF_WIDTH-1:0]       tap_coef;
  logic signed [ACC_WIDTH-1:0] tap_prod;
  logic signed [ACC_WIDTH-1:0] acc_sum;

  assign tap_val  = win_q.value[32'(tap_cnt_q) * DATA_WIDTH +: DATA_WIDTH];
  assign tap_coef = win_q.coef[32'(tap_cnt_q) * COEF_WIDTH +: COEF_WIDTH];

  tap_mul u_tap_mul (
    .data_i (tap_val),
    .coef_i (tap_coef),
    .prod_o (tap_prod)
  );

  assign acc_sum = acc_q + tap_prod;

  assign bus.window_req = (state_q == ST_IDLE);
  assign bus.out_result = res_q.result;
  assign bus.out_addr   = res_q.addr;
  assign bus.out_spike  = res_q.spike;
  assign bus.out_valid  = out_valid_q;
  assign bus.overrun    = overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      win_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      acc_q       <= acc_d;
      win_q       <= win_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    acc_d       = acc_q;
    win_d       = win_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    // A window offered while busy is dropped and flagged until reset.
    if (bus.in_window_valid && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.in_window_valid) begin
          win_d.value = bus.in_window_value;
          win_d.coef  = bus.kernel_coef;
          win_d.thr   = bus.threshold;
          win_d.addr  = bus.in_window_addr;
          acc_d       = '0;
          tap_cnt_d   = '0;
          state_d     = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d     = acc_sum;
        tap_cnt_d = tap_cnt_q + 1'b1;
        if (tap_cnt_q == CNT_WIDTH'(TAPS - 1)) begin
          res_d.result = acc_sum;
          res_d.addr   = win_q.addr;
          res_d.spike  = (acc_sum >= $signed(win_q.thr));
          out_valid_d  = 1'b1;
          state_d      = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_window_conv_mac.sv
// Self-checking bench for window_conv_mac: directed scenarios plus randomized windows vs. an arithmetic model.
module tb_window_conv_mac;
  import window_conv_mac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  int          cur_v [TAPS];
  int          cur_c [TAPS];
  logic [15:0] cur_addr;
  int          cur_thr;

  window_conv_mac_if bus ();

  window_conv_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain integer dot product of zero-extended values and signed coefficients.
  function automatic int model_sum();
    int s = 0;
    for (int k = 0; k < int'(TAPS); k++) s += cur_v[k] * cur_c[k];
    return s;
  endfunction

  function automatic int got_result();
    logic signed [ACC_WIDTH-1:0] r;
    r = bus.out_result;
    return int'(r);
  endfunction

  task automatic set_window(input int v0, input int vstep, input int c, input logic [15:0] a, input int t);
    for (int k = 0; k < int'(TAPS); k++) begin
      cur_v[k] = v0 + vstep * k;
      cur_c[k] = c;
    end
    cur_addr = a;
    cur_thr  = t;
  endtask

  task automatic set_random_window();
    for (int k = 0; k < int'(TAPS); k++) begin
      cur_v[k] = int'($urandom_range(15));
      cur_c[k] = int'($urandom_range(255)) - 128;
    end
    cur_addr = 16'($urandom);
    cur_thr  = int'($urandom_range(6000)) - 3000;
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < int'(TAPS); k++) begin
      bus.in_window_value[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(cur_v[k]);
      bus.kernel_coef[k*COEF_WIDTH +: COEF_WIDTH]     = COEF_WIDTH'(cur_c[k]);
    end
    bus.in_window_addr = cur_addr;
    bus.threshold      = ACC_WIDTH'(cur_thr);
  endtask

  task automatic send_window();
    int n = 0;
    while (!bus.window_req && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.window_req) begin
      total++; bad++;
      $display("FAIL window_req_timeout: got 0 expected 1");
    end
    drive_inputs();
    bus.in_window_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_window_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (!bus.out_valid) begin
      total++; bad++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.out_valid !== 1'b0)  begin bad++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    total++; if (bus.out_result !== '0)   begin bad++; $display("FAIL rst_out_result: got %h expected 0", bus.out_result); end
    total++; if (bus.out_addr !== 16'h0)  begin bad++; $display("FAIL rst_out_addr: got %h expected 0", bus.out_addr); end
    total++; if (bus.out_spike !== 1'b0)  begin bad++; $display("FAIL rst_out_spike: got %b expected 0", bus.out_spike); end
    total++; if (bus.overrun !== 1'b0)    begin bad++; $display("FAIL rst_overrun: got %b expected 0", bus.overrun); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.window_req !== 1'b1) begin bad++; $display("FAIL rst_window_req: got %b expected 1", bus.window_req); end
  endtask

  task automatic test_basic();
    int cyc;
    set_window(1, 1, 1, 16'h0203, 0);
    send_window();
    wait_valid(cyc);
    total++; if (cyc != int'(TAPS)) begin bad++; $display("FAIL basic_latency: got %0d expected %0d", cyc, TAPS); end
    total++; if (got_result() != 45) begin bad++; $display("FAIL basic_result: got %0d expected 45", got_result()); end
    total++; if (bus.out_addr !== 16'h0203) begin bad++; $display("FAIL basic_addr: got %h expected 0203", bus.out_addr); end
    total++; if (bus.out_spike !== 1'b1) begin bad++; $display("FAIL basic_spike: got %b expected 1", bus.out_spike); end
    accept();
    total++; if (bus.out_valid !== 1'b0 || bus.window_req !== 1'b1) begin
      bad++; $display("FAIL basic_handshake: got valid=%b req=%b expected valid=0 req=1", bus.out_valid, bus.window_req);
    end
  endtask

  task automatic test_negative();
    int cyc;
    set_window(15, 0, -128, 16'h1111, 0);
    send_window();
    wait_valid(cyc);
    total++; if (bus.out_result !== 17'h1BC80) begin bad++; $display("FAIL neg_result: got %h expected 1bc80", bus.out_result); end
    total++; if (got_result() != -17280) begin bad++; $display("FAIL neg_model: got %0d expected -17280", got_result()); end
    total++; if (bus.out_spike !== 1'b0) begin bad++; $display("FAIL neg_spike: got %b expected 0", bus.out_spike); end
    accept();
  endtask

  task automatic test_backpressure();
    int cyc;
    int exp_sum;
    set_random_window();
    exp_sum = model_sum();
    send_window();
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b1 || got_result() != exp_sum || bus.out_addr !== cur_addr || bus.window_req !== 1'b0) begin
        bad++; $display("FAIL bp_hold: got valid=%b res=%0d addr=%h req=%b expected valid=1 res=%0d addr=%h req=0",
                        bus.out_valid, got_result(), bus.out_addr, bus.window_req, exp_sum, cur_addr);
      end
    end
    accept();
    total++; if (bus.out_valid !== 1'b0 || bus.window_req !== 1'b1) begin
      bad++; $display("FAIL bp_release: got valid=%b req=%b expected valid=0 req=1", bus.out_valid, bus.window_req);
    end
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_single_transfer: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_coef_change();
    int cyc;
    set_window(1, 1, 1, 16'h0203, 0);
    send_window();
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.kernel_coef = '0;
    bus.threshold   = ACC_WIDTH'(1000);
    wait_valid(cyc);
    total++; if (got_result() != 45) begin bad++; $display("FAIL coef_change_result: got %0d expected 45", got_result()); end
    total++; if (bus.out_spike !== 1'b1) begin bad++; $display("FAIL coef_change_spike: got %b expected 1", bus.out_spike); end
    accept();
  endtask

  task automatic test_overrun();
    int cyc;
    set_window(1, 1, 1, 16'h0203, 0);
    send_window();
    repeat (3) begin @(posedge clk); #1; end
    bus.in_window_value = '1;
    bus.in_window_addr  = 16'hFFFF;
    bus.in_window_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_window_valid = 1'b0;
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
    wait_valid(cyc);
    total++; if (got_result() != 45 || bus.out_addr !== 16'h0203) begin
      bad++; $display("FAIL overrun_result: got %0d/%h expected 45/0203", got_result(), bus.out_addr);
    end
    accept();
    repeat (3) begin @(posedge clk); #1; end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b expected 1", bus.overrun); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    set_random_window();
    send_window();
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.out_result !== '0) begin
      bad++; $display("FAIL midrst_clear: got valid=%b ovr=%b res=%h expected 0/0/0", bus.out_valid, bus.overrun, bus.out_result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.window_req !== 1'b1) begin bad++; $display("FAIL midrst_req: got %b expected 1", bus.window_req); end
    set_window(1, 1, 1, 16'h0203, 0);
    send_window();
    wait_valid(cyc);
    total++; if (got_result() != 45 || cyc != int'(TAPS)) begin
      bad++; $display("FAIL midrst_next: got %0d after %0d cycles expected 45 after %0d", got_result(), cyc, TAPS);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    int cyc;
    int exp_sum;
    bus.out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      set_random_window();
      exp_sum = model_sum();
      send_window();
      wait_valid(cyc);
      total++; if (got_result() != exp_sum || bus.out_addr !== cur_addr) begin
        bad++; $display("FAIL b2b_result: got %0d/%h expected %0d/%h", got_result(), bus.out_addr, exp_sum, cur_addr);
      end
    end
    bus.out_ready = 1'b0;
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b expected 0", bus.overrun); end
    accept();
  endtask

  task automatic test_random();
    int cyc;
    int exp_sum;
    bit exp_spike;
    for (int it = 0; it < 25; it++) begin
      set_random_window();
      exp_sum = model_sum();
      if (it % 3 == 0) cur_thr = exp_sum + (it % 2);
      exp_spike = (exp_sum >= cur_thr);
      send_window();
      wait_valid(cyc);
      repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      total++; if (got_result() != exp_sum) begin bad++; $display("FAIL rand_result: got %0d expected %0d", got_result(), exp_sum); end
      total++; if (bus.out_addr !== cur_addr) begin bad++; $display("FAIL rand_addr: got %h expected %h", bus.out_addr, cur_addr); end
      total++; if (bus.out_spike !== exp_spike) begin
        bad++; $display("FAIL rand_spike: got %b expected %b (sum %0d thr %0d)", bus.out_spike, exp_spike, exp_sum, cur_thr);
      end
      accept();
    end
  endtask

  initial begin
    bus.in_window_value = '0;
    bus.in_window_addr  = '0;
    bus.in_window_valid = 1'b0;
    bus.kernel_coef     = '0;
    bus.threshold       = '0;
    bus.out_ready       = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_coef_change();
    test_overrun();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
